// File: rtl/width_converter_down_if.sv
// Bus bundle for width_converter_down.
//   sink_*   : InWidth-bit word side (valid/ready, data, beat count, last)
//   source_* : OutWidth-bit beat side (valid/ready, data, last)
// Modport slave is the converter's view; master is the environment's view.
interface width_converter_down_if #(
    parameter int unsigned InWidth  = 32,
    parameter int unsigned OutWidth = 8
);
    localparam int unsigned CntW = $clog2(InWidth / OutWidth + 1);

    logic                sink_valid_i;
    logic                sink_ready_o;
    logic [InWidth-1:0]  sink_data_i;
    logic [CntW-1:0]     sink_beats_i;
    logic                sink_last_i;
    logic                source_valid_o;
    logic                source_ready_i;
    logic [OutWidth-1:0] source_data_o;
    logic                source_last_o;

    modport slave (
        input  sink_valid_i, sink_data_i, sink_beats_i, sink_last_i, source_ready_i,
        output sink_ready_o, source_valid_o, source_data_o, source_last_o
    );

    modport master (
        output sink_valid_i, sink_data_i, sink_beats_i, sink_last_i, source_ready_i,
        input  sink_ready_o, source_valid_o, source_data_o, source_last_o
    );
endinterface

// File: rtl/width_converter_down.sv
// N-to-M down-converter: splits InWidth-bit words into OutWidth-bit beats,
// lowest slice first, with per-word beat count, message-last propagation,
// synchronous flush and one beat per cycle via hold register + bypass.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   flush_i : synchronous flush, drops all buffered data
//   bus     : sink word / source beat handshakes (width_converter_down_if.slave)
//   busy_o  : any data buffered
module width_converter_down #(
    parameter int unsigned InWidth  = 32,
    parameter int unsigned OutWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    width_converter_down_if.slave bus,
    output logic                  busy_o
);
    localparam int unsigned Ratio = InWidth / OutWidth;
    localparam int unsigned CntW  = $clog2(Ratio + 1);

    if ((InWidth % OutWidth) != 0) begin : g_chk_ratio
        $error("width_converter_down: InWidth must be a multiple of OutWidth");
    end
    if ((OutWidth % 8) != 0) begin : g_chk_bytes
        $error("width_converter_down: OutWidth must be a multiple of 8");
    end

    // Shift stage
    logic [InWidth-1:0] sreg;
    logic [CntW-1:0]    scnt;
    logic               slast;
    // Hold stage
    logic [InWidth-1:0] hdata;
    logic [CntW-1:0]    hbeats;
    logic               hlast;
    logic               hvalid;

    logic            src_xfer;
    logic            sink_xfer;
    logic            shift_free;
    logic [CntW-1:0] beats_eff;

    assign bus.source_valid_o = (scnt != '0) & ~flush_i;
    assign bus.source_data_o  = sreg[OutWidth-1:0];
    assign bus.source_last_o  = slast & (scnt == CntW'(1));
    assign bus.sink_ready_o   = ~hvalid & ~flush_i;
    assign busy_o             = (scnt != '0) | hvalid;

    assign src_xfer   = bus.source_valid_o & bus.source_ready_i;
    assign sink_xfer  = bus.sink_valid_i & bus.sink_ready_o;
    assign shift_free = (scnt == '0) | ((scnt == CntW'(1)) & src_xfer);

    // Zero means a full word; oversized counts saturate at a full word.
    always_comb begin
        beats_eff = bus.sink_beats_i;
        if ((bus.sink_beats_i == '0) || (bus.sink_beats_i > CntW'(Ratio))) begin
            beats_eff = CntW'(Ratio);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sreg   <= '0;
            scnt   <= '0;
            slast  <= 1'b0;
            hdata  <= '0;
            hbeats <= '0;
            hlast  <= 1'b0;
            hvalid <= 1'b0;
        end else if (flush_i) begin
            scnt   <= '0;
            slast  <= 1'b0;
            hvalid <= 1'b0;
        end else if (shift_free) begin
            if (hvalid) begin
                sreg   <= hdata;
                scnt   <= hbeats;
                slast  <= hlast;
                hvalid <= 1'b0;
                if (sink_xfer) begin
                    hdata  <= bus.sink_data_i;
                    hbeats <= beats_eff;
                    hlast  <= bus.sink_last_i;
                    hvalid <= 1'b1;
                end
            end else if (sink_xfer) begin
                // Bypass: the word goes straight to the shift stage.
                sreg  <= bus.sink_data_i;
                scnt  <= beats_eff;
                slast <= bus.sink_last_i;
            end else if (src_xfer) begin
                // Final beat leaves with nothing queued behind it.
                scnt <= '0;
            end
        end else begin
            if (src_xfer) begin
                sreg <= sreg >> OutWidth;
                scnt <= scnt - CntW'(1);
            end
            if (sink_xfer) begin
                hdata  <= bus.sink_data_i;
                hbeats <= beats_eff;
                hlast  <= bus.sink_last_i;
                hvalid <= 1'b1;
            end
        end
    end
endmodule
